// File: rtl/bcd_7seg_pkg.sv
// Shared types and glyph constants for the BCD 7-segment scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high (1 lights a segment).
package bcd_7seg_pkg;

    typedef logic [6:0] seg_t;

    // Bit order of a seg_t: bit 6 = g ... bit 0 = a.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_fields_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b1111100;
    localparam seg_t SEG_C     = 7'b0111001;
    localparam seg_t SEG_D     = 7'b1011110;
    localparam seg_t SEG_E     = 7'b1111001;
    localparam seg_t SEG_F     = 7'b1110001;
    localparam seg_t SEG_DASH  = 7'b1000000;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_7seg_decode.sv
// Combinational nibble-to-glyph lookup (active-high segments).
// Codes 10-15 render as hex letters when BCD_7SEG_HEX_EN is defined, else as a dash.
module bcd_7seg_decode
    import bcd_7seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
`ifdef BCD_7SEG_HEX_EN
            4'd10:   o_seg = SEG_A;
            4'd11:   o_seg = SEG_B;
            4'd12:   o_seg = SEG_C;
            4'd13:   o_seg = SEG_D;
            4'd14:   o_seg = SEG_E;
            4'd15:   o_seg = SEG_F;
`endif
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed BCD display driver: prescaler, digit scan, anti-tearing load,
// leading-zero blanking and registered outputs. Hex glyphs via BCD_7SEG_HEX_EN.
module bcd_7seg_scan_driver
    import bcd_7seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    input  logic                          load,
    input  logic                          blank_en,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PS_W  = $clog2(CLK_DIV);

    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam seg_t                  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [PS_W-1:0]         r_presc;
    logic [IDX_W-1:0]        r_digit_idx;
    logic                    r_frame_done;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic [4*NUM_DIGITS-1:0] r_display;
    seg_t                    r_seg;
    logic [NUM_DIGITS-1:0]   r_anode;

    logic                    w_tick;
    logic                    w_wrap;
    logic [3:0]              w_nibble;
    logic [NUM_DIGITS-1:0]   w_blank_mask;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;
    seg_t                    w_glyph;
    seg_t                    w_seg_int;

    assign w_tick = (r_presc == PS_LAST);
    assign w_wrap = w_tick && (r_digit_idx == IDX_LAST);

    always_comb begin
        w_nibble = 4'd0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nibble    = r_display[4*i +: 4];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // A digit is blanked while every nibble from the top down to it is zero;
    // bit 0 is never set so the rightmost digit always shows.
    always_comb begin
        logic v_zero_run;
        v_zero_run   = blank_en;
        w_blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_zero_run      = v_zero_run && (r_display[4*i +: 4] == 4'd0);
            w_blank_mask[i] = v_zero_run;
        end
    end

    assign w_blank = w_blank_mask[r_digit_idx];

    bcd_7seg_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    assign w_seg_int = w_blank ? SEG_BLANK : w_glyph;

    // load is a single-cycle strobe with no back-pressure; the display register only
    // changes on the wrap tick so a frame is never drawn from two different values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
            r_pending    <= '0;
            r_display    <= '0;
            r_seg        <= SEG_OFF;
            r_anode      <= AN_OFF;
        end else begin
            r_presc      <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
            end
            r_frame_done <= w_wrap;
            if (load) begin
                r_pending <= bcd_in;
            end
            if (w_wrap) begin
                r_display <= load ? bcd_in : r_pending;
            end
            r_seg        <= SEG_ACTIVE_LOW ? ~w_seg_int : w_seg_int;
            r_anode      <= AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

    assign seg        = r_seg;
    assign anode      = r_anode;
    assign digit_idx  = r_digit_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench for bcd_7seg_scan_driver (NUM_DIGITS=4, CLK_DIV=4, active-low outputs).
// Expected digit slots are queued by the stimulus; a monitor pops one whenever anode changes.
module tb_bcd_7seg_scan_driver;

    localparam int W = 14;  // {anode[3:0], seg[6:0], digit_idx[1:0], frame_done}

    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G2   = 7'b0100100;
    localparam logic [6:0] G3   = 7'b0110000;
    localparam logic [6:0] G4   = 7'b0011001;
    localparam logic [6:0] G6   = 7'b0000010;
    localparam logic [6:0] G7   = 7'b1111000;
    localparam logic [6:0] G9   = 7'b0010000;
    localparam logic [6:0] GOFF = 7'h7F;
`ifdef BCD_7SEG_HEX_EN
    localparam logic [6:0] GB   = 7'b0000011;
    localparam logic [6:0] GF   = 7'b0001110;
`else
    localparam logic [6:0] GB   = 7'b0111111;
    localparam logic [6:0] GF   = 7'b0111111;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] bcd_in;
    logic        load;
    logic        blank_en;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        frame_done;

    logic [W-1:0] exp_q[$];
    int           checks;
    int           errors;
    bit           mon_en;

    bcd_7seg_scan_driver #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .blank_en   (blank_en),
        .seg        (seg),
        .anode      (anode),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic push_slot(input logic [3:0] an, input logic [6:0] s, input logic [1:0] idx);
        exp_q.push_back({an, s, idx, 1'b0});
    endtask

    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
        push_slot(4'b1110, s0, 2'd0);
        push_slot(4'b1101, s1, 2'd1);
        push_slot(4'b1011, s2, 2'd2);
        push_slot(4'b0111, s3, 2'd3);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("frame_done_wait", {31'd0, seen}, 32'd1);
    endtask

    // Called right after a frame boundary: strobes load 7 cycles into the frame.
    task automatic mid_load(input logic [15:0] v, input bit blank);
        repeat (6) @(posedge clk);
        #1;
        bcd_in   = v;
        load     = 1'b1;
        blank_en = blank;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [3:0]   prev_anode;
        logic [W-1:0] rec;
        int           cyc;
        int           last_chg;
        int           fd_last;
        bit           fd_valid;
        prev_anode = 'x;
        cyc        = 0;
        last_chg   = 0;
        fd_last    = 0;
        fd_valid   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (anode !== prev_anode) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL slot_unexpected actual anode=%b seg=%b required=no slot @%0t",
                                 anode, seg, $time);
                    end else begin
                        rec = exp_q.pop_front();
                        chk("anode", {28'd0, anode}, {28'd0, rec[13:10]});
                        chk("seg", {25'd0, seg}, {25'd0, rec[9:3]});
                        chk("digit_idx", {30'd0, digit_idx}, {30'd0, rec[2:1]});
                        chk("frame_done_slot", {31'd0, frame_done}, {31'd0, rec[0]});
                    end
                    if (!$isunknown(prev_anode) && prev_anode !== 4'hF && anode !== 4'hF)
                        chk("slot_len", cyc - last_chg, 32'd4);
                    last_chg   = cyc;
                    prev_anode = anode;
                end
                if (rst) begin
                    fd_valid = 1'b0;
                end else if (frame_done === 1'b1) begin
                    chk("frame_done_idx", {30'd0, digit_idx}, 32'd0);
                    if (fd_valid)
                        chk("frame_done_period", cyc - fd_last, 32'd16);
                    fd_valid = 1'b1;
                    fd_last  = cyc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b1;
        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'h0000;
        blank_en = 1'b0;

        // Reset state, then frames A and B of zeros.
        exp_q.push_back({4'hF, GOFF, 2'd0, 1'b0});
        push_frame(G0, G0, G0, G0);
        push_frame(G0, G0, G0, G0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("release_cycle1_anode", {28'd0, anode}, 32'hF);
        @(negedge clk);
        chk("release_cycle2_anode", {28'd0, anode}, 32'hE);

        // Frame B: mid-frame load must not tear; frame C shows 1234.
        wait_fd();
        mid_load(16'h1234, 1'b0);
        push_frame(G1, G2, G3, G4);

        // Frame D: 000B without blanking.
        wait_fd();
        mid_load(16'h000B, 1'b0);
        push_frame(G0, G0, G0, GB);

        // Frame E: 90F6.
        wait_fd();
        mid_load(16'h90F6, 1'b0);
        push_frame(G9, G0, GF, G6);

        // Frame F: 0070 with leading-zero blanking.
        wait_fd();
        mid_load(16'h0070, 1'b1);
        push_frame(GOFF, GOFF, G7, G0);

        // Frame G: 0000 blanked, interrupted by reset after its second digit.
        wait_fd();
        mid_load(16'h0000, 1'b1);
        push_slot(4'b1110, G0, 2'd0);
        push_slot(4'b1101, GOFF, 2'd1);
        exp_q.push_back({4'hF, GOFF, 2'd0, 1'b0});

        wait_fd();
        repeat (6) @(posedge clk);
        #1;
        bcd_in = 16'h5678;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load     = 1'b0;
        rst      = 1'b1;
        blank_en = 1'b0;
        // Frames H and I show zeros (5678 discarded); load on the wrap tick lands in J and K.
        push_frame(G0, G0, G0, G0);
        push_frame(G0, G0, G0, G0);
        push_frame(G4, G3, G2, G1);
        push_frame(G4, G3, G2, G1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        wait_fd();
        repeat (15) @(posedge clk);
        #1;
        bcd_in = 16'h4321;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load   = 1'b0;
        bcd_in = 16'h0000;

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 32'd0);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_7seg_scan_driver.md
Name: bcd_7seg_scan_driver

Overview:
- Multi-digit, time-multiplexed BCD to 7-segment display driver.
- Holds a packed BCD word and scans one digit at a time at a programmable refresh rate.
- Drives shared segment lines plus one-hot digit enables.
- Sits between the datapath producing BCD values and the board-level common-anode display.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 1000, clk cycles each digit stays lit (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (0 lights a segment)
AN_ACTIVE_LOW, 1, 1 = anode outputs inverted (0 enables a digit)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
bcd_in  input  4*NUM_DIGITS  packed BCD value; nibble 0 is the least significant / rightmost digit
load  input  1  capture bcd_in this cycle
blank_en  input  1  enable leading-zero blanking
seg  output  7  segments {g,f,e,d,c,b,a}; registered
anode  output  NUM_DIGITS  one-hot digit enable; registered
digit_idx  output  clog2(NUM_DIGITS)  index of the digit currently driven
frame_done  output  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - prescaler = 0, digit_idx = 0.
  - pending and display registers cleared to 0.
  - frame_done = 0.
  - seg all segments off: 7'h7F when SEG_ACTIVE_LOW, else 7'h00.
  - anode all digits inactive.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - The terminal count produces a tick.
  - On a tick, digit_idx increments and wraps NUM_DIGITS-1 -> 0.
- frame_done: asserted for exactly the cycle in which digit_idx wraps to 0.
- Anti-tearing load:
  - load copies bcd_in into the pending register.
  - The display register updates only at a frame boundary, i.e. the wrap tick: display <= pending.
  - If load and the wrap tick coincide, display <= bcd_in directly, and pending also takes bcd_in.
  - Repeated loads within one frame: the last one wins.
- Output timing:
  - seg and anode are registered from digit_idx and display, so they lag digit_idx by 1 cycle.
  - First cycle after rst deasserts: outputs still inactive.
  - Second cycle after rst deasserts: digit 0 lit.
- Decode rules:
  - Digits 0-9 map to the standard glyphs.
  - Codes 10-15: see Optional Feature.
- Leading-zero blanking:
  - Digit i is blanked when blank_en=1 and every nibble from NUM_DIGITS-1 down to i is 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode active with all segments off, so scan timing is unchanged.
- Polarity: internal logic is active-high; inversion is applied at the output register only.
- Reset mid-scan: takes effect next edge regardless of prescaler state; a pending load is discarded.

Optional Feature:
- Macro: BCD_7SEG_HEX_EN.
- Defined: codes 10-15 display A, b, C, d, E, F.
  - Active-high {g..a} values: 1110111, 1111100, 0111001, 1011110, 1111001, 1110001.
- Undefined: codes 10-15 display a dash (segment g only, 1000000 active-high).

Decomposition:
- Package bcd_7seg_pkg holds:
  - the 7-bit segment typedef;
  - glyph constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_DASH, SEG_BLANK;
  - the segment bit-order definition.
- Sub-module bcd_7seg_decode: purely combinational nibble-to-glyph lookup, honouring BCD_7SEG_HEX_EN.
- Top level owns the prescaler, scan counter, pending/display registers, blanking logic and output registers.

Test Plan:
Parameters for all scenarios: NUM_DIGITS=4, CLK_DIV=4, both active-low.
1. Hold rst 3 cycles -> seg=7'h7F, anode=4'hF, frame_done=0, digit_idx=0. Release -> anode=4'b1110 two cycles after release.
2. Free run -> anode sequence 1110, 1101, 1011, 0111, each held 4 cycles. frame_done pulses once every 16 cycles.
3. Pulse load with bcd_in=16'h1234 mid-frame -> displayed digits unchanged until the next frame_done. Afterwards digit0 seg=7'b0011001 ("4") and digit3 seg=7'b1111001 ("1").
4. blank_en=1, load 16'h0070 -> digits 3 and 2 show 7'h7F, digit1 shows "7" (7'b1111000), digit0 shows "0" (7'b1000000). Load 16'h0000 -> only digit0 lit, showing "0".
5. Load nibble 4'hB -> without macro seg=7'b0111111 (dash); with BCD_7SEG_HEX_EN seg=7'b0000011 ("b").
6. Load 16'h5678 and pulse rst before the frame boundary -> next cycle outputs inactive. After release, all digits show "0" (the pending value was discarded).
